// File: rtl/mod_74x163_chain_pkg.sv
// ---------------------------------------------------------------------------
// mod_74x163_chain_pkg
//   Shared definitions for the cascaded 74x163 counter.
//   - SECTION_W / SECTION_MAX : width and terminal value of one 4-bit section
//   - sec_op_t                : the action a section takes at a clock edge
//   - decode_op()             : load/count/hold priority of one section
//   Reset is not part of decode_op; it is applied directly in the state
//   register so it always wins, whatever the other controls are doing.
// ---------------------------------------------------------------------------
package mod_74x163_chain_pkg;

  localparam int unsigned SECTION_W = 4;
  localparam logic [SECTION_W-1:0] SECTION_MAX = 4'hF;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_COUNT = 2'd2
  } sec_op_t;

  // Load beats counting and ignores both enables. Counting needs ENP and
  // this section's ENT together; anything else holds the section.
  function automatic sec_op_t decode_op(input logic ld_n,
                                        input logic enp,
                                        input logic ent);
    sec_op_t op;
    op = OP_HOLD;
    if (!ld_n) begin
      op = OP_LOAD;
    end else if (enp && ent) begin
      op = OP_COUNT;
    end
    return op;
  endfunction

  // Terminal-count decode for one section, gated by its ENT input.
  function automatic logic section_rco(input logic ent,
                                       input logic [SECTION_W-1:0] q);
    return ent && (q == SECTION_MAX);
  endfunction

endpackage

// File: rtl/mod_74x163_chain_if.sv
// ---------------------------------------------------------------------------
// mod_74x163_chain_if
//   Control/data bundle of the cascaded counter.
//   LD_N : synchronous parallel load, active low
//   ENP  : count enable P (all sections, does not gate RCO)
//   ENT  : count enable T (lowest section, gates RCO)
//   D    : parallel load data, bit 0 is the LSB
//   Q    : counter state, bit 0 is the LSB
//   RCO  : ripple-carry out of the top section (combinational)
//   master : the side driving the controls (e.g. a testbench or sequencer)
//   slave  : the counter itself
//   STAGES must match the STAGES of the counter it is connected to.
// ---------------------------------------------------------------------------
interface mod_74x163_chain_if
  import mod_74x163_chain_pkg::*;
#(
  parameter int unsigned STAGES = 2
) ();

  logic                          LD_N;
  logic                          ENP;
  logic                          ENT;
  logic [SECTION_W*STAGES-1:0]   D;
  logic [SECTION_W*STAGES-1:0]   Q;
  logic                          RCO;

  modport master (
    output LD_N,
    output ENP,
    output ENT,
    output D,
    input  Q,
    input  RCO
  );

  modport slave (
    input  LD_N,
    input  ENP,
    input  ENT,
    input  D,
    output Q,
    output RCO
  );

endinterface

// File: rtl/mod_74x163_chain_slice.sv
// ---------------------------------------------------------------------------
// mod_74x163_slice
//   One 4-bit synchronous presettable binary counter section (74x163).
//   CLK  : rising-edge clock
//   RST  : synchronous active-high clear (replaces CLR_N)
//   LD_N : synchronous parallel load, active low, ignores the enables
//   ENP  : count enable P
//   ENT  : count enable T, also gates RCO
//   D    : load data
//   Q    : section state
//   RCO  : ENT AND (Q == 4'hF), combinational
// ---------------------------------------------------------------------------
module mod_74x163_slice
  import mod_74x163_chain_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 LD_N,
  input  logic                 ENP,
  input  logic                 ENT,
  input  logic [SECTION_W-1:0] D,
  output logic [SECTION_W-1:0] Q,
  output logic                 RCO
);

  logic [SECTION_W-1:0] q_reg;
  logic [SECTION_W-1:0] q_next;
  sec_op_t              op;

  // D is only looked at on the load branch, so an unknown D cannot reach
  // the register while LD_N is high.
  always_comb begin
    q_next = q_reg;
    op     = decode_op(LD_N, ENP, ENT);
    unique case (op)
      OP_LOAD:  q_next = D;
      OP_COUNT: q_next = q_reg + SECTION_W'(1);
      default:  q_next = q_reg;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q   = q_reg;
  assign RCO = section_rco(ENT, q_reg);

endmodule

// File: rtl/mod_74x163_chain.sv
// ---------------------------------------------------------------------------
// mod_74x163_chain
//   Synchronous presettable binary counter of 4*STAGES bits built from
//   cascaded 74x163 sections.
//   CLK : rising-edge clock
//   RST : synchronous active-high reset, Q <= 0
//   bus : mod_74x163_chain_if.slave carrying LD_N, ENP, ENT, D, Q, RCO
//   Section i gets ENT from the RCO of section i-1 (section 0 gets ENT),
//   so the top RCO equals ENT AND (Q all ones) with no register in the path.
//   ENP fans out to every section unchanged.
// ---------------------------------------------------------------------------
module mod_74x163_chain
  import mod_74x163_chain_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  mod_74x163_chain_if.slave        bus
);

  localparam int unsigned W = SECTION_W * STAGES;

  // ent_chain[i] is the ENT seen by section i; ent_chain[STAGES] is the
  // carry out of the top section.
  logic [STAGES:0]  ent_chain;
  logic [W-1:0]     q_all;
  logic [W-1:0]     d_all;

  assign ent_chain[0] = bus.ENT;
  assign d_all        = bus.D;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_section
      mod_74x163_slice u_slice (
        .CLK  (CLK),
        .RST  (RST),
        .LD_N (bus.LD_N),
        .ENP  (bus.ENP),
        .ENT  (ent_chain[gi]),
        .D    (d_all[gi*SECTION_W +: SECTION_W]),
        .Q    (q_all[gi*SECTION_W +: SECTION_W]),
        .RCO  (ent_chain[gi+1])
      );
    end
  endgenerate

  assign bus.Q   = q_all;
  assign bus.RCO = ent_chain[STAGES];

endmodule
